vram_arbiter: RTL

- Shares the single-port video RAM between the VGA scanline fetcher and the CPU data bus.
- Issues at most one memory operation per clk cycle; video fetch has priority.
- A bounded-wait guard guarantees CPU forward progress.
- Read data returns one cycle after issue and is routed back to the owner of that slot.

---
 rtl/vram_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: the video scanline fetcher has priority, and a
// bounded-wait guard forces a pending CPU access through after MAX_CPU_WAIT denials.
module vram_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_CPU_WAIT    = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vid_req,
    input  logic [ADDR_WIDTH-1:0]      vid_addr,
    output logic                       vid_gnt,
    output logic                       vid_rvalid,
    output logic [DATA_WIDTH-1:0]      vid_rdata,
    input  logic                       cpu_rd_en,
    input  logic                       cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0]      cpu_addr,
    input  logic [DATA_WIDTH-1:0]      cpu_wr_data,
    input  logic [DATA_WIDTH/8-1:0]    cpu_wr_strobe,
    output logic                       cpu_ack,
    output logic [DATA_WIDTH-1:0]      cpu_rd_data,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DATA_WIDTH/8-1:0]    mem_wstrb,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [STALL_CNT_WIDTH-1:0] vid_stall_cnt
);

    typedef enum logic {C_IDLE, C_ACK} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;

    cpu_state_t state;
    owner_t     owner;
    logic [7:0] wait_cnt;
    logic       vid_rvalid_q;
    logic       cpu_pending;
    logic       force_cpu;
    logic       grant_vid;
    logic       grant_cpu;
    logic       cpu_write;

    assign cpu_pending = (cpu_rd_en | cpu_wr_en) && (state == C_IDLE);
    assign force_cpu   = cpu_pending && (wait_cnt >= 8'(MAX_CPU_WAIT));
    assign grant_vid   = !rst && vid_req && !force_cpu;
    assign grant_cpu   = !rst && !grant_vid && cpu_pending;
    // Write wins when both CPU strobes are raised together.
    assign cpu_write   = grant_cpu && cpu_wr_en;

    assign vid_gnt   = grant_vid;
    assign mem_en    = grant_vid | grant_cpu;
    assign mem_we    = cpu_write;
    assign mem_addr  = grant_vid ? vid_addr : cpu_addr;
    assign mem_wdata = cpu_write ? cpu_wr_data : '0;
    assign mem_wstrb = cpu_write ? cpu_wr_strobe : '0;

    // Masking with rst drops a read that was in flight when reset arrived.
    assign vid_rvalid  = vid_rvalid_q && !rst;
    assign cpu_ack     = (state == C_ACK) && !rst;
    assign vid_rdata   = (vid_rvalid && owner == OWN_VID) ? mem_rdata : '0;
    assign cpu_rd_data = (cpu_ack && owner == OWN_CPU) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= C_IDLE;
            owner         <= OWN_NONE;
            wait_cnt      <= '0;
            vid_rvalid_q  <= 1'b0;
            vid_stall_cnt <= '0;
        end else begin
            vid_rvalid_q <= grant_vid;

            case (state)
                C_IDLE: if (grant_cpu) state <= C_ACK;
                C_ACK:  state <= C_IDLE;
            endcase

            if (grant_vid)
                owner <= OWN_VID;
            else if (grant_cpu && !cpu_wr_en)
                owner <= OWN_CPU;
            else
                owner <= OWN_NONE;

            if (grant_cpu)
                wait_cnt <= '0;
            else if (cpu_pending && wait_cnt < 8'(MAX_CPU_WAIT))
                wait_cnt <= wait_cnt + 8'd1;

            if (vid_req && !grant_vid && vid_stall_cnt != '1)
                vid_stall_cnt <= vid_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

endmodule
